// File: rtl/axil_mitm_pkg.sv
// -----------------------------------------------------------------------------
// axil_mitm_pkg
// Shared constants and helpers for the AXI4-lite write-channel MITM pipe.
//   RESP_OKAY / RESP_SLVERR : AXI response encodings
//   cnt_width()             : bits needed to hold 0..outstanding inclusive
// -----------------------------------------------------------------------------
package axil_mitm_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    function automatic int cnt_width(input int outstanding);
        return $clog2(outstanding + 1);
    endfunction

endpackage

// File: rtl/axil_mitm_fifo.sv
// -----------------------------------------------------------------------------
// axil_mitm_fifo
// Small synchronous FIFO with registered pointers and a fill counter.
// Read data is the current head entry (first-word fall-through).
//   clk, rst       : clock, synchronous active-high reset (pointers/count only)
//   push_i, data_i : write strobe and data (ignored while full)
//   pop_i          : read strobe (ignored while empty)
//   data_o         : head entry, meaningful only while !empty_o
//   full_o,empty_o : status flags
// -----------------------------------------------------------------------------
module axil_mitm_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             push_ok, pop_ok;

    // Pointers wrap explicitly so non-power-of-two depths stay correct too.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign data_o  = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push_ok) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (pop_ok)  rd_ptr_d = ptr_inc(rd_ptr_q);
        if (push_ok && !pop_ok)      cnt_d = cnt_q + CW'(1);
        else if (pop_ok && !push_ok) cnt_d = cnt_q - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage is payload only; no reset needed.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/axil_mitm_wr_pipe.sv
// -----------------------------------------------------------------------------
// axil_mitm_wr_pipe
// AXI4-lite write-channel man-in-the-middle. AW, W and B are each forwarded
// through one register stage with full throughput; AW and W are accepted
// independently, each limited to OUTSTANDING writes awaiting a response.
// Every completed write produces a one-cycle monitor record.
//   clk, rst          : clock, synchronous active-high reset
//   s_axil_aw*/w*/b*  : upstream (interconnect master) side
//   m_axil_aw*/w*/b*  : downstream (peripheral) side
//   mon_valid, mon_*  : monitor record {addr, prot, data, strb, resp}
// Optional build macro AXIL_MITM_WR_ERR_INJECT_EN adds inj_en/inj_addr: a
// response for a write whose address equals inj_addr is forced to SLVERR.
// -----------------------------------------------------------------------------
module axil_mitm_wr_pipe
    import axil_mitm_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int STRB_WIDTH  = DATA_WIDTH / 8,
    parameter int OUTSTANDING = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
    input  logic [2:0]            s_axil_awprot,
    input  logic                  s_axil_awvalid,
    output logic                  s_axil_awready,
    input  logic [DATA_WIDTH-1:0] s_axil_wdata,
    input  logic [STRB_WIDTH-1:0] s_axil_wstrb,
    input  logic                  s_axil_wvalid,
    output logic                  s_axil_wready,
    output logic [1:0]            s_axil_bresp,
    output logic                  s_axil_bvalid,
    input  logic                  s_axil_bready,
    output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
    output logic [2:0]            m_axil_awprot,
    output logic                  m_axil_awvalid,
    input  logic                  m_axil_awready,
    output logic [DATA_WIDTH-1:0] m_axil_wdata,
    output logic [STRB_WIDTH-1:0] m_axil_wstrb,
    output logic                  m_axil_wvalid,
    input  logic                  m_axil_wready,
    input  logic [1:0]            m_axil_bresp,
    input  logic                  m_axil_bvalid,
    output logic                  m_axil_bready,
    output logic                  mon_valid,
    output logic [ADDR_WIDTH-1:0] mon_addr,
    output logic [2:0]            mon_prot,
    output logic [DATA_WIDTH-1:0] mon_data,
    output logic [STRB_WIDTH-1:0] mon_strb,
    output logic [1:0]            mon_resp
`ifdef AXIL_MITM_WR_ERR_INJECT_EN
    ,
    input  logic                  inj_en,
    input  logic [ADDR_WIDTH-1:0] inj_addr
`endif
);

    localparam int            CW      = cnt_width(OUTSTANDING);
    localparam logic [CW-1:0] CNT_MAX = CW'(OUTSTANDING);
    localparam int            AFW     = ADDR_WIDTH + 3;
    localparam int            DFW     = DATA_WIDTH + STRB_WIDTH;

    logic                  m_awvalid_q, m_wvalid_q, s_bvalid_q, mon_valid_q;
    logic [ADDR_WIDTH-1:0] m_awaddr_q, mon_addr_q;
    logic [2:0]            m_awprot_q, mon_prot_q;
    logic [DATA_WIDTH-1:0] m_wdata_q, mon_data_q;
    logic [STRB_WIDTH-1:0] m_wstrb_q, mon_strb_q;
    logic [1:0]            s_bresp_q, mon_resp_q;
    logic [CW-1:0]         aw_cnt_q, aw_cnt_d, w_cnt_q, w_cnt_d;

    logic           aw_hs, w_hs, m_b_hs, s_b_hs, mon_pop;
    logic [AFW-1:0] addr_head;
    logic [DFW-1:0] data_head;
    logic           addr_full, addr_empty, data_full, data_empty;
    logic [1:0]     b_resp_fwd;

    // Saturating up/down counter step; simultaneous inc and dec cancel.
    function automatic logic [CW-1:0] cnt_next(input logic [CW-1:0] c,
                                               input logic inc, input logic dec);
        logic [CW-1:0] r;
        r = c;
        if (inc && !dec && c != CNT_MAX)   r = c + CW'(1);
        else if (dec && !inc && c != '0)   r = c - CW'(1);
        return r;
    endfunction

    // Readies are held low while reset is asserted.
    assign s_axil_awready = !rst && (!m_awvalid_q || m_axil_awready) && (aw_cnt_q < CNT_MAX);
    assign s_axil_wready  = !rst && (!m_wvalid_q || m_axil_wready) && (w_cnt_q < CNT_MAX);
    assign m_axil_bready  = !rst && (!s_bvalid_q || s_axil_bready);

    assign aw_hs   = s_axil_awvalid && s_axil_awready;
    assign w_hs    = s_axil_wvalid && s_axil_wready;
    assign m_b_hs  = m_axil_bvalid && m_axil_bready;
    assign s_b_hs  = s_bvalid_q && s_axil_bready;
    // A response with no recorded request is forwarded but not monitored.
    assign mon_pop = m_b_hs && !addr_empty && !data_empty;

    assign aw_cnt_d = cnt_next(aw_cnt_q, aw_hs, s_b_hs);
    assign w_cnt_d  = cnt_next(w_cnt_q, w_hs, s_b_hs);

`ifdef AXIL_MITM_WR_ERR_INJECT_EN
    assign b_resp_fwd = (inj_en && !addr_empty && addr_head[ADDR_WIDTH-1:0] == inj_addr)
                        ? RESP_SLVERR : m_axil_bresp;
`else
    assign b_resp_fwd = m_axil_bresp;
`endif

    // The full guards are redundant with the counter gating on the readies.
    axil_mitm_fifo #(.WIDTH(AFW), .DEPTH(OUTSTANDING)) u_addr_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (aw_hs && !addr_full),
        .data_i  ({s_axil_awprot, s_axil_awaddr}),
        .pop_i   (mon_pop),
        .data_o  (addr_head),
        .full_o  (addr_full),
        .empty_o (addr_empty)
    );

    axil_mitm_fifo #(.WIDTH(DFW), .DEPTH(OUTSTANDING)) u_data_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (w_hs && !data_full),
        .data_i  ({s_axil_wstrb, s_axil_wdata}),
        .pop_i   (mon_pop),
        .data_o  (data_head),
        .full_o  (data_full),
        .empty_o (data_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            m_awvalid_q <= 1'b0;
            m_wvalid_q  <= 1'b0;
            s_bvalid_q  <= 1'b0;
            mon_valid_q <= 1'b0;
            aw_cnt_q    <= '0;
            w_cnt_q     <= '0;
        end else begin
            if (aw_hs)               m_awvalid_q <= 1'b1;
            else if (m_axil_awready) m_awvalid_q <= 1'b0;
            if (w_hs)                m_wvalid_q  <= 1'b1;
            else if (m_axil_wready)  m_wvalid_q  <= 1'b0;
            if (m_b_hs)              s_bvalid_q  <= 1'b1;
            else if (s_axil_bready)  s_bvalid_q  <= 1'b0;
            mon_valid_q <= mon_pop;
            aw_cnt_q    <= aw_cnt_d;
            w_cnt_q     <= w_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (aw_hs) begin
            m_awaddr_q <= s_axil_awaddr;
            m_awprot_q <= s_axil_awprot;
        end
        if (w_hs) begin
            m_wdata_q <= s_axil_wdata;
            m_wstrb_q <= s_axil_wstrb;
        end
        if (m_b_hs) s_bresp_q <= b_resp_fwd;
        if (mon_pop) begin
            mon_addr_q <= addr_head[ADDR_WIDTH-1:0];
            mon_prot_q <= addr_head[AFW-1:ADDR_WIDTH];
            mon_data_q <= data_head[DATA_WIDTH-1:0];
            mon_strb_q <= data_head[DFW-1:DATA_WIDTH];
            mon_resp_q <= b_resp_fwd;
        end
    end

    assign m_axil_awvalid = m_awvalid_q;
    assign m_axil_awaddr  = m_awaddr_q;
    assign m_axil_awprot  = m_awprot_q;
    assign m_axil_wvalid  = m_wvalid_q;
    assign m_axil_wdata   = m_wdata_q;
    assign m_axil_wstrb   = m_wstrb_q;
    assign s_axil_bvalid  = s_bvalid_q;
    assign s_axil_bresp   = s_bresp_q;
    assign mon_valid      = mon_valid_q;
    assign mon_addr       = mon_addr_q;
    assign mon_prot       = mon_prot_q;
    assign mon_data       = mon_data_q;
    assign mon_strb       = mon_strb_q;
    assign mon_resp       = mon_resp_q;

endmodule

// File: tb/tb_axil_mitm_wr_pipe.sv
// -----------------------------------------------------------------------------
// tb_axil_mitm_wr_pipe
// Directed bench: upstream requests come from queues, a small downstream
// responder answers once both AW and W of a write have been forwarded, and
// every handshake / monitor record is logged for comparison against
// hand-computed values.
// -----------------------------------------------------------------------------
module tb_axil_mitm_wr_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] s_axil_awaddr = '0;
    logic [2:0]  s_axil_awprot = '0;
    logic        s_axil_awvalid = 1'b0;
    logic        s_axil_awready;
    logic [31:0] s_axil_wdata = '0;
    logic [3:0]  s_axil_wstrb = '0;
    logic        s_axil_wvalid = 1'b0;
    logic        s_axil_wready;
    logic [1:0]  s_axil_bresp;
    logic        s_axil_bvalid;
    logic        s_axil_bready = 1'b1;
    logic [31:0] m_axil_awaddr;
    logic [2:0]  m_axil_awprot;
    logic        m_axil_awvalid;
    logic        m_axil_awready = 1'b1;
    logic [31:0] m_axil_wdata;
    logic [3:0]  m_axil_wstrb;
    logic        m_axil_wvalid;
    logic        m_axil_wready = 1'b1;
    logic [1:0]  m_axil_bresp = '0;
    logic        m_axil_bvalid = 1'b0;
    logic        m_axil_bready;
    logic        mon_valid;
    logic [31:0] mon_addr;
    logic [2:0]  mon_prot;
    logic [31:0] mon_data;
    logic [3:0]  mon_strb;
    logic [1:0]  mon_resp;
`ifdef AXIL_MITM_WR_ERR_INJECT_EN
    logic        inj_en = 1'b0;
    logic [31:0] inj_addr = '0;
`endif

    axil_mitm_wr_pipe dut (
        .clk(clk), .rst(rst),
        .s_axil_awaddr(s_axil_awaddr), .s_axil_awprot(s_axil_awprot),
        .s_axil_awvalid(s_axil_awvalid), .s_axil_awready(s_axil_awready),
        .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb),
        .s_axil_wvalid(s_axil_wvalid), .s_axil_wready(s_axil_wready),
        .s_axil_bresp(s_axil_bresp), .s_axil_bvalid(s_axil_bvalid),
        .s_axil_bready(s_axil_bready),
        .m_axil_awaddr(m_axil_awaddr), .m_axil_awprot(m_axil_awprot),
        .m_axil_awvalid(m_axil_awvalid), .m_axil_awready(m_axil_awready),
        .m_axil_wdata(m_axil_wdata), .m_axil_wstrb(m_axil_wstrb),
        .m_axil_wvalid(m_axil_wvalid), .m_axil_wready(m_axil_wready),
        .m_axil_bresp(m_axil_bresp), .m_axil_bvalid(m_axil_bvalid),
        .m_axil_bready(m_axil_bready),
        .mon_valid(mon_valid), .mon_addr(mon_addr), .mon_prot(mon_prot),
        .mon_data(mon_data), .mon_strb(mon_strb), .mon_resp(mon_resp)
`ifdef AXIL_MITM_WR_ERR_INJECT_EN
        , .inj_en(inj_en), .inj_addr(inj_addr)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc_n  = 0;

    // Pending upstream requests: {prot, addr} and {strb, data}.
    logic [34:0] aw_req_q[$];
    logic [35:0] w_req_q[$];

    // Downstream responder state.
    int          n_m_aw = 0, n_m_w = 0, n_m_b = 0;
    logic        slave_en = 1'b1;
    logic [1:0]  slave_resp = 2'b00;

    // Observation logs.
    int          s_aw_cyc_q[$], s_w_cyc_q[$], m_aw_cyc_q[$], s_b_cyc_q[$];
    logic [31:0] m_aw_addr_q[$];
    logic [35:0] m_w_q[$];
    logic [1:0]  s_b_resp_q[$];
    logic [31:0] mon_addr_q[$], mon_data_q[$];
    logic [3:0]  mon_strb_q[$];
    logic [2:0]  mon_prot_q[$];
    logic [1:0]  mon_resp_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_inputs();
        s_axil_awvalid = (aw_req_q.size() != 0);
        if (aw_req_q.size() != 0) {s_axil_awprot, s_axil_awaddr} = aw_req_q[0];
        s_axil_wvalid = (w_req_q.size() != 0);
        if (w_req_q.size() != 0) {s_axil_wstrb, s_axil_wdata} = w_req_q[0];
        m_axil_bvalid = slave_en && (((n_m_aw < n_m_w) ? n_m_aw : n_m_w) > n_m_b);
        m_axil_bresp  = slave_resp;
    endtask

    task automatic clear_obs();
        s_aw_cyc_q.delete(); s_w_cyc_q.delete(); m_aw_cyc_q.delete(); s_b_cyc_q.delete();
        m_aw_addr_q.delete(); m_w_q.delete(); s_b_resp_q.delete();
        mon_addr_q.delete(); mon_data_q.delete(); mon_strb_q.delete();
        mon_prot_q.delete(); mon_resp_q.delete();
    endtask

    // One clock: observe just after the falling edge, drive just after the
    // rising edge, return at the next falling edge.
    task automatic cyc();
        logic aw_acc, w_acc;
        #1;
        cyc_n++;
        aw_acc = s_axil_awvalid && s_axil_awready;
        w_acc  = s_axil_wvalid && s_axil_wready;
        if (aw_acc) s_aw_cyc_q.push_back(cyc_n);
        if (w_acc)  s_w_cyc_q.push_back(cyc_n);
        if (m_axil_awvalid && m_axil_awready) begin
            n_m_aw++;
            m_aw_cyc_q.push_back(cyc_n);
            m_aw_addr_q.push_back(m_axil_awaddr);
        end
        if (m_axil_wvalid && m_axil_wready) begin
            n_m_w++;
            m_w_q.push_back({m_axil_wstrb, m_axil_wdata});
        end
        if (m_axil_bvalid && m_axil_bready) n_m_b++;
        if (s_axil_bvalid && s_axil_bready) begin
            s_b_resp_q.push_back(s_axil_bresp);
            s_b_cyc_q.push_back(cyc_n);
        end
        if (mon_valid) begin
            mon_addr_q.push_back(mon_addr);
            mon_data_q.push_back(mon_data);
            mon_strb_q.push_back(mon_strb);
            mon_prot_q.push_back(mon_prot);
            mon_resp_q.push_back(mon_resp);
        end
        @(posedge clk);
        #1;
        if (aw_acc) void'(aw_req_q.pop_front());
        if (w_acc)  void'(w_req_q.pop_front());
        drive_inputs();
        @(negedge clk);
    endtask

    initial begin
        // ---------------- reset ----------------
        drive_inputs();
        @(negedge clk);
        chk("rst_m_awvalid", m_axil_awvalid, 0);
        chk("rst_m_wvalid", m_axil_wvalid, 0);
        chk("rst_s_bvalid", s_axil_bvalid, 0);
        chk("rst_mon_valid", mon_valid, 0);
        chk("rst_s_awready", s_axil_awready, 0);
        chk("rst_s_wready", s_axil_wready, 0);
        chk("rst_m_bready", m_axil_bready, 0);
        rst = 1'b0;
        cyc();
        chk("idle_s_awready", s_axil_awready, 1);
        chk("idle_s_wready", s_axil_wready, 1);

        // ---------------- single write ----------------
        clear_obs();
        aw_req_q.push_back({3'b001, 32'h0000_0100});
        w_req_q.push_back({4'hF, 32'hDEAD_BEEF});
        drive_inputs();
        repeat (12) cyc();
        chk("t1_aw_acc", s_aw_cyc_q.size(), 1);
        chk("t1_m_aw", m_aw_cyc_q.size(), 1);
        if (s_aw_cyc_q.size() == 1 && m_aw_cyc_q.size() == 1) begin
            chk("t1_aw_latency", m_aw_cyc_q[0] - s_aw_cyc_q[0], 1);
            chk("t1_m_awaddr", m_aw_addr_q[0], 32'h100);
        end
        chk("t1_m_w", m_w_q.size(), 1);
        if (m_w_q.size() == 1) chk("t1_m_wdata", m_w_q[0], {4'hF, 32'hDEAD_BEEF});
        chk("t1_mon_cnt", mon_addr_q.size(), 1);
        if (mon_addr_q.size() == 1) begin
            chk("t1_mon_addr", mon_addr_q[0], 32'h100);
            chk("t1_mon_prot", mon_prot_q[0], 3'b001);
            chk("t1_mon_data", mon_data_q[0], 32'hDEAD_BEEF);
            chk("t1_mon_strb", mon_strb_q[0], 4'hF);
            chk("t1_mon_resp", mon_resp_q[0], 2'b00);
        end
        chk("t1_b_cnt", s_b_resp_q.size(), 1);
        if (s_b_resp_q.size() == 1) chk("t1_bresp", s_b_resp_q[0], 2'b00);

        // ---------------- W three cycles before AW ----------------
        clear_obs();
        slave_resp = 2'b11;
        w_req_q.push_back({4'h3, 32'h1234_5678});
        drive_inputs();
        repeat (3) cyc();
        aw_req_q.push_back({3'b101, 32'h0000_0ABC});
        drive_inputs();
        repeat (12) cyc();
        chk("t2_aw_acc", s_aw_cyc_q.size(), 1);
        chk("t2_w_acc", s_w_cyc_q.size(), 1);
        if (s_aw_cyc_q.size() == 1 && s_w_cyc_q.size() == 1)
            chk("t2_w_lead", s_aw_cyc_q[0] - s_w_cyc_q[0], 3);
        if (m_aw_addr_q.size() == 1) chk("t2_m_awaddr", m_aw_addr_q[0], 32'hABC);
        if (m_w_q.size() == 1) chk("t2_m_wdata", m_w_q[0], {4'h3, 32'h1234_5678});
        chk("t2_mon_cnt", mon_addr_q.size(), 1);
        if (mon_addr_q.size() == 1) begin
            chk("t2_mon_addr", mon_addr_q[0], 32'hABC);
            chk("t2_mon_prot", mon_prot_q[0], 3'b101);
            chk("t2_mon_data", mon_data_q[0], 32'h1234_5678);
            chk("t2_mon_strb", mon_strb_q[0], 4'h3);
            chk("t2_mon_resp", mon_resp_q[0], 2'b11);
        end
        if (s_b_resp_q.size() == 1) chk("t2_bresp", s_b_resp_q[0], 2'b11);
        slave_resp = 2'b00;

        // ---------------- outstanding limit with bready stalled ----------------
        clear_obs();
        s_axil_bready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            aw_req_q.push_back({3'b000, 32'h1000 + 32'(i * 4)});
            w_req_q.push_back({4'hF, 32'hA000_0000 + 32'(i)});
        end
        drive_inputs();
        repeat (15) cyc();
        chk("t3_aw_acc_stall", s_aw_cyc_q.size(), 4);
        chk("t3_w_acc_stall", s_w_cyc_q.size(), 4);
        chk("t3_awready_low", s_axil_awready, 0);
        chk("t3_wready_low", s_axil_wready, 0);
        chk("t3_bvalid_held", s_axil_bvalid, 1);
        chk("t3_mon_stall", mon_addr_q.size(), 1);
        s_axil_bready = 1'b1;
        chk("t3_awready_before_b", s_axil_awready, 0);
        cyc();
        chk("t3_first_b", s_b_cyc_q.size(), 1);
        chk("t3_awready_resume", s_axil_awready, 1);
        chk("t3_wready_resume", s_axil_wready, 1);
        repeat (30) cyc();
        chk("t3_aw_acc_total", s_aw_cyc_q.size(), 6);
        chk("t3_b_total", s_b_resp_q.size(), 6);
        chk("t3_mon_cnt", mon_addr_q.size(), 6);
        if (mon_addr_q.size() == 6)
            for (int i = 0; i < 6; i++) begin
                chk($sformatf("t3_mon_addr%0d", i), mon_addr_q[i], 32'h1000 + 32'(i * 4));
                chk($sformatf("t3_mon_data%0d", i), mon_data_q[i], 32'hA000_0000 + 32'(i));
            end

        // ---------------- back-to-back throughput ----------------
        clear_obs();
        for (int i = 0; i < 8; i++) begin
            aw_req_q.push_back({3'b010, 32'h2000 + 32'(i * 16)});
            w_req_q.push_back({4'hF, 32'hB0 + 32'(i)});
        end
        drive_inputs();
        repeat (20) cyc();
        chk("t4_aw_acc", s_aw_cyc_q.size(), 8);
        chk("t4_w_acc", s_w_cyc_q.size(), 8);
        chk("t4_b_cnt", s_b_cyc_q.size(), 8);
        if (s_aw_cyc_q.size() == 8) chk("t4_aw_span", s_aw_cyc_q[7] - s_aw_cyc_q[0], 7);
        if (s_w_cyc_q.size() == 8)  chk("t4_w_span", s_w_cyc_q[7] - s_w_cyc_q[0], 7);
        if (s_b_cyc_q.size() == 8)  chk("t4_b_span", s_b_cyc_q[7] - s_b_cyc_q[0], 7);
        chk("t4_mon_cnt", mon_addr_q.size(), 8);
        if (mon_addr_q.size() == 8)
            for (int i = 0; i < 8; i++)
                chk($sformatf("t4_mon_addr%0d", i), mon_addr_q[i], 32'h2000 + 32'(i * 16));

        // ---------------- reset with writes in flight ----------------
        clear_obs();
        slave_en = 1'b0;
        m_axil_awready = 1'b0;
        aw_req_q.push_back({3'b000, 32'h3000});
        aw_req_q.push_back({3'b000, 32'h3004});
        w_req_q.push_back({4'hF, 32'h1111_1111});
        w_req_q.push_back({4'hF, 32'h2222_2222});
        drive_inputs();
        repeat (5) cyc();
        chk("t5_aw_acc_pre", s_aw_cyc_q.size(), 1);
        chk("t5_m_awvalid_pre", m_axil_awvalid, 1);
        aw_req_q.delete();
        w_req_q.delete();
        rst = 1'b1;
        drive_inputs();
        cyc();
        chk("t5_m_awvalid_rst", m_axil_awvalid, 0);
        chk("t5_m_wvalid_rst", m_axil_wvalid, 0);
        chk("t5_s_bvalid_rst", s_axil_bvalid, 0);
        chk("t5_mon_valid_rst", mon_valid, 0);
        chk("t5_s_awready_rst", s_axil_awready, 0);
        rst = 1'b0;
        m_axil_awready = 1'b1;
        slave_en = 1'b1;
        n_m_aw = 0; n_m_w = 0; n_m_b = 0;
        clear_obs();
        drive_inputs();
        cyc();
        aw_req_q.push_back({3'b011, 32'h0000_0300});
        w_req_q.push_back({4'h5, 32'h55AA_55AA});
        drive_inputs();
        repeat (12) cyc();
        chk("t5_b_cnt", s_b_resp_q.size(), 1);
        chk("t5_mon_cnt", mon_addr_q.size(), 1);
        if (mon_addr_q.size() == 1) begin
            chk("t5_mon_addr", mon_addr_q[0], 32'h300);
            chk("t5_mon_prot", mon_prot_q[0], 3'b011);
            chk("t5_mon_data", mon_data_q[0], 32'h55AA_55AA);
            chk("t5_mon_strb", mon_strb_q[0], 4'h5);
        end

`ifdef AXIL_MITM_WR_ERR_INJECT_EN
        // ---------------- error injection ----------------
        clear_obs();
        inj_en = 1'b1;
        inj_addr = 32'h200;
        aw_req_q.push_back({3'b000, 32'h1FC});
        aw_req_q.push_back({3'b000, 32'h200});
        aw_req_q.push_back({3'b000, 32'h204});
        for (int i = 0; i < 3; i++) w_req_q.push_back({4'hF, 32'hC0 + 32'(i)});
        drive_inputs();
        repeat (15) cyc();
        chk("t6_b_cnt", s_b_resp_q.size(), 3);
        chk("t6_mon_cnt", mon_resp_q.size(), 3);
        if (s_b_resp_q.size() == 3) begin
            chk("t6_bresp0", s_b_resp_q[0], 2'b00);
            chk("t6_bresp1", s_b_resp_q[1], 2'b10);
            chk("t6_bresp2", s_b_resp_q[2], 2'b00);
        end
        if (mon_resp_q.size() == 3) begin
            chk("t6_mon_resp0", mon_resp_q[0], 2'b00);
            chk("t6_mon_resp1", mon_resp_q[1], 2'b10);
            chk("t6_mon_resp2", mon_resp_q[2], 2'b00);
            chk("t6_mon_addr1", mon_addr_q[1], 32'h200);
        end
        inj_en = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
